mdr_seq_ctrl: RTL and testbench
===============================

// Module: mdr_seq_ctrl
// PURPOSE
//   Parametrised sequencer for the multiply/divide/square-root (MDR) datapath.
//   Runs each operation: clear, load X, load Y, verify operands, iterate, deliver result.
//   Adds over the previous controller: per-op iteration count, edge-detected loads,
//   wait timeout, an ERROR state and a ready/ack result handshake.
//   Sits between the top-level user inputs (start/op/load) and the MDR datapath.
// PARAMETERS
//   DW        16          operand width; MUL and DIV iterate DW cycles
//   SQRT_IT   DW/2        SQRT iteration count
//   TMO       255         max cycles spent in WAIT_X/WAIT_Y before abort (0 = never abort)
//   CW        $clog2(DW+1) width of the iteration counter
// PORTS
//   clk       in   1    clock, rising edge
//   rst       in   1    asynchronous reset, active low
//   start     in   1    request new operation, active high, sampled in IDLE only
//   op        in   2    0=MUL 1=DIV 2=SQRT 3=illegal; captured on accepted start
//   load      in   1    level input; a rising edge loads the current operand
//   w_error   in   1    datapath operand check (div by 0, neg sqrt), valid in VERIFY
//   ack       in   1    result consumed, sampled in READY/ERROR
//   clean     out  1    clear datapath registers
//   load_x    out  1    one-cycle strobe: capture X
//   load_y    out  1    one-cycle strobe: capture Y
//   veri      out  1    datapath evaluates operands
//   enable    out  1    datapath iterate strobe
//   ready     out  1    result valid, held until ack
//   error     out  1    operation aborted, held until ack
//   busy      out  1    state != IDLE
//   op_q      out  2    captured op, stable from CLEAN to return to IDLE
//   count     out  CW   current iteration index (0 outside CALC)
// BEHAVIOUR
//   Reset: state=IDLE; every output 0; count=0; op_q=0; timeout counter=0; load edge reg=0.
//     Applies asynchronously mid-operation; the in-flight op is discarded.
//   All outputs are decoded from registered state/counters only (no input-to-output path).
//   load edge: load_q <= load every cycle; ld_rise = load & ~load_q.
//   States and transitions (evaluated at the rising edge):
//     IDLE   : start -> CLEAN, op_q<=op. Otherwise stay. start outside IDLE is ignored.
//     CLEAN  : clean=1; -> WAIT_X unconditionally (1 cycle).
//     WAIT_X : ld_rise -> LOAD_X; tmo hit -> ERROR.
//     LOAD_X : load_x=1 (1 cycle); -> WAIT_Y.
//     WAIT_Y : ld_rise -> LOAD_Y; tmo hit -> ERROR.
//     LOAD_Y : load_y=1 (1 cycle); -> VERIFY.
//     VERIFY : veri=1 (1 cycle); w_error or op_q==3 -> ERROR, else -> CALC.
//     CALC   : enable=1; count increments from 0; at count==N-1 -> READY, count<=0.
//              N = DW for MUL/DIV, SQRT_IT for SQRT. enable is high exactly N cycles.
//     READY  : ready=1; ack -> IDLE (ack in the first READY cycle is accepted).
//     ERROR  : error=1; ack -> IDLE.
//   Timeout: counter clears on entry to WAIT_X/WAIT_Y and counts each cycle there;
//     "tmo hit" = counter==TMO-1 with no ld_rise that cycle. ld_rise on that cycle wins.
//   A load level held high across WAIT_X->WAIT_Y does not load Y; a new rising edge is needed.
//   Latency: start at edge k -> CLEAN in cycle k+1; MUL, loads back to back:
//     ready first high 6+DW cycles after start is sampled.
//   busy = (state != IDLE). Illegal state encodings return to IDLE on the next edge.
// TESTING
//   DW=16, MUL, start, load edges 3 cycles apart, ack after 2 -> enable high exactly 16 cycles,
//     load_x/load_y single-cycle pulses, ready held 2 cycles, then IDLE.
//   SQRT -> enable high exactly 8 cycles; DIV with w_error=1 in VERIFY -> ERROR, enable never high.
//   op=3 -> ERROR after VERIFY; ack -> IDLE; start pulsed during CALC -> ignored, op_q unchanged.
//   TMO=10, no load edge after CLEAN -> error=1 on the 11th cycle after entering WAIT_X;
//     load held high from before start -> no load_x strobe.
//   rst low during CALC at count=5 -> all outputs 0 immediately; IDLE after rst release.
//   ld_rise on the same cycle as tmo hit -> LOAD_X taken, no error.

Source files
------------

// File: rtl/mdr_seq_ctrl_if.sv
// Handshake bundle between the MDR sequencer and its user/datapath neighbours.
// The master drives the requests, operands and acks; the slave is the sequencer.
interface mdr_seq_ctrl_if #(
  parameter int CW = 5
);
  logic          start;
  logic [1:0]    op;
  logic          load;
  logic          w_error;
  logic          ack;
  logic          clean;
  logic          load_x;
  logic          load_y;
  logic          veri;
  logic          enable;
  logic          ready;
  logic          error;
  logic          busy;
  logic [1:0]    op_q;
  logic [CW-1:0] count;

  modport master (
    output start, op, load, w_error, ack,
    input  clean, load_x, load_y, veri, enable, ready, error, busy, op_q, count
  );

  modport slave (
    input  start, op, load, w_error, ack,
    output clean, load_x, load_y, veri, enable, ready, error, busy, op_q, count
  );
endinterface

// File: rtl/mdr_seq_ctrl.sv
// Sequencer for the multiply/divide/square-root datapath: clear, load X, load Y,
// verify, iterate, then hold ready/error until acknowledged.
module mdr_seq_ctrl #(
  parameter int DW      = 16,
  parameter int SQRT_IT = DW / 2,
  parameter int TMO     = 255,
  parameter int CW      = $clog2(DW + 1)
) (
  input logic           clk,
  input logic           rst,
  mdr_seq_ctrl_if.slave bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAN, S_WAIT_X, S_LOAD_X, S_WAIT_Y,
    S_LOAD_Y, S_VERIFY, S_CALC, S_READY, S_ERROR
  } state_t;

  localparam int            TW       = (TMO < 2) ? 1 : $clog2(TMO);
  localparam logic [TW-1:0] TMO_LAST = TW'((TMO > 0) ? TMO - 1 : 0);
  localparam logic [CW-1:0] LAST_MD  = CW'(DW - 1);
  localparam logic [CW-1:0] LAST_SQ  = CW'(SQRT_IT - 1);
  localparam logic [1:0]    OP_SQRT  = 2'd2;
  localparam logic [1:0]    OP_BAD   = 2'd3;

  state_t        state_q, state_d;
  logic [1:0]    op_r, op_d;
  logic [CW-1:0] count_q, count_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          load_q;
  logic          ld_rise;
  logic          tmo_hit;
  logic          last_iter;
  logic          in_wait;

  assign ld_rise   = bus.load & ~load_q;
  // A load edge on the final timeout cycle still wins over the abort.
  assign tmo_hit   = (TMO != 0) && (tmo_q == TMO_LAST) && !ld_rise;
  assign last_iter = (count_q == ((op_r == OP_SQRT) ? LAST_SQ : LAST_MD));
  assign in_wait   = (state_q == S_WAIT_X) || (state_q == S_WAIT_Y);

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    op_d    = op_r;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CLEAN;
          op_d    = bus.op;
        end
      end
      S_CLEAN:  state_d = S_WAIT_X;
      S_WAIT_X: begin
        if (ld_rise)      state_d = S_LOAD_X;
        else if (tmo_hit) state_d = S_ERROR;
      end
      S_LOAD_X: state_d = S_WAIT_Y;
      S_WAIT_Y: begin
        if (ld_rise)      state_d = S_LOAD_Y;
        else if (tmo_hit) state_d = S_ERROR;
      end
      S_LOAD_Y: state_d = S_VERIFY;
      S_VERIFY: state_d = (bus.w_error || (op_r == OP_BAD)) ? S_ERROR : S_CALC;
      S_CALC:   if (last_iter) state_d = S_READY;
      S_READY:  if (bus.ack) state_d = S_IDLE;
      S_ERROR:  if (bus.ack) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Both counters restart whenever their state is (re)entered or left.
    tmo_d   = (in_wait && (state_d == state_q)) ? tmo_q + 1'b1 : '0;
    count_d = ((state_q == S_CALC) && (state_d == S_CALC)) ? count_q + 1'b1 : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_r    <= '0;
      count_q <= '0;
      tmo_q   <= '0;
      load_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      op_r    <= op_d;
      count_q <= count_d;
      tmo_q   <= tmo_d;
      load_q  <= bus.load;
    end
  end

  assign bus.clean  = (state_q == S_CLEAN);
  assign bus.load_x = (state_q == S_LOAD_X);
  assign bus.load_y = (state_q == S_LOAD_Y);
  assign bus.veri   = (state_q == S_VERIFY);
  assign bus.enable = (state_q == S_CALC);
  assign bus.ready  = (state_q == S_READY);
  assign bus.error  = (state_q == S_ERROR);
  assign bus.busy   = (state_q != S_IDLE);
  assign bus.op_q   = op_r;
  assign bus.count  = count_q;

endmodule

// File: tb/tb_mdr_seq_ctrl.sv
// Directed bench for mdr_seq_ctrl (DW=16, SQRT_IT=8, TMO=10): full operations,
// error paths, timeout boundaries, load-edge rules and asynchronous reset.
module tb_mdr_seq_ctrl;

  localparam int DW      = 16;
  localparam int SQRT_IT = 8;
  localparam int TMO     = 10;
  localparam int CW      = $clog2(DW + 1);
  localparam int NEVER   = 1000;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  mdr_seq_ctrl_if #(.CW(CW)) bus ();

  mdr_seq_ctrl #(
    .DW(DW), .SQRT_IT(SQRT_IT), .TMO(TMO), .CW(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int en, lx, ly, veri, clean, rdy, err, t_rdy, t_err, t_idle;
    bit cnt_bad, opq_bad;
  } res_t;

  function automatic logic [14:0] out_vec();
    return {bus.clean, bus.load_x, bus.load_y, bus.veri, bus.enable, bus.ready,
            bus.error, bus.busy, bus.op_q, bus.count};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation from IDLE. t=0 is the CLEAN cycle; loads pulse at x_t/y_t,
  // load is held high from hold_from on, start is re-pulsed at glitch_t.
  task automatic do_op(input logic [1:0] o, input int x_t, input int y_t, input int hold_from,
                       input bit werr, input int ack_dly, input int glitch_t, output res_t r);
    int resp;
    r = '{default: 0};
    r.t_rdy = -1; r.t_err = -1; r.t_idle = -1;
    resp = 0;
    bus.w_error = werr;
    bus.ack     = 1'b0;
    bus.load    = (hold_from < 0);
    tick();
    bus.start = 1'b1;
    bus.op    = o;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (!bus.busy) begin
        r.t_idle = t;
        break;
      end
      if (bus.enable) begin
        if (bus.count !== CW'(r.en)) r.cnt_bad = 1'b1;
        r.en++;
      end else if (bus.count !== '0) begin
        r.cnt_bad = 1'b1;
      end
      if (bus.op_q !== o) r.opq_bad = 1'b1;
      if (bus.load_x) r.lx++;
      if (bus.load_y) r.ly++;
      if (bus.veri)   r.veri++;
      if (bus.clean)  r.clean++;
      if (bus.ready) begin
        if (r.t_rdy < 0) r.t_rdy = t;
        r.rdy++;
        resp++;
      end
      if (bus.error) begin
        if (r.t_err < 0) r.t_err = t;
        r.err++;
        resp++;
      end
      bus.ack   = (bus.ready || bus.error) && (resp >= ack_dly);
      bus.load  = (t == x_t) || (t == y_t) || (t >= hold_from);
      bus.start = (t == glitch_t);
      bus.op    = (t == glitch_t) ? 2'd2 : o;
      tick();
    end
    if (r.t_idle < 0) begin
      total++; bad++;
      $display("FAIL op_bound: op=%0d did not return to IDLE within 200 cycles", o);
    end
    bus.ack = 1'b0; bus.load = 1'b0; bus.start = 1'b0; bus.w_error = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.op = 2'd0; bus.load = 1'b0; bus.w_error = 1'b0; bus.ack = 1'b0;
    rst = 1'b0;
    #3;
    total++; if (out_vec() !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", out_vec()); end
    bus.start = 1'b1;
    tick(); tick();
    total++; if (out_vec() !== '0) begin bad++; $display("FAIL reset_held: got %h want 0", out_vec()); end
    bus.start = 1'b0;
    @(negedge clk) rst = 1'b1;
    tick();
    total++; if (out_vec() !== '0) begin bad++; $display("FAIL reset_release: got %h want 0", out_vec()); end
  endtask

  task automatic test_mul();
    res_t r;
    do_op(2'd0, 1, 4, NEVER, 1'b0, 2, NEVER, r);
    total++; if (r.en !== 16)   begin bad++; $display("FAIL mul_enable_cycles: got %0d want 16", r.en); end
    total++; if (r.lx !== 1 || r.ly !== 1) begin bad++; $display("FAIL mul_load_strobes: got x=%0d y=%0d want 1/1", r.lx, r.ly); end
    total++; if (r.clean !== 1 || r.veri !== 1) begin bad++; $display("FAIL mul_clean_veri: got %0d/%0d want 1/1", r.clean, r.veri); end
    total++; if (r.t_rdy !== 23) begin bad++; $display("FAIL mul_ready_time: got %0d want 23", r.t_rdy); end
    total++; if (r.rdy !== 2 || r.err !== 0) begin bad++; $display("FAIL mul_ready_hold: got rdy=%0d err=%0d want 2/0", r.rdy, r.err); end
    total++; if (r.t_idle !== 25) begin bad++; $display("FAIL mul_idle_time: got %0d want 25", r.t_idle); end
    total++; if (r.cnt_bad || r.opq_bad) begin bad++; $display("FAIL mul_count_opq: got cnt_bad=%0d opq_bad=%0d want 0/0", r.cnt_bad, r.opq_bad); end
  endtask

  task automatic test_back_to_back();
    res_t r;
    do_op(2'd0, 1, 3, NEVER, 1'b0, 1, NEVER, r);
    total++; if (r.t_rdy !== 22) begin bad++; $display("FAIL b2b_latency: got %0d want 22", r.t_rdy); end
    total++; if (r.t_idle !== 23) begin bad++; $display("FAIL b2b_ack_first: got %0d want 23", r.t_idle); end
    do_op(2'd1, 1, 3, NEVER, 1'b0, 1, NEVER, r);
    total++; if (r.en !== 16 || r.t_rdy !== 22) begin bad++; $display("FAIL div_ok: got en=%0d rdy_t=%0d want 16/22", r.en, r.t_rdy); end
    total++; if (r.opq_bad || r.err !== 0) begin bad++; $display("FAIL div_ok_opq: got opq_bad=%0d err=%0d want 0/0", r.opq_bad, r.err); end
  endtask

  task automatic test_sqrt();
    res_t r;
    do_op(2'd2, 1, 3, NEVER, 1'b0, 1, NEVER, r);
    total++; if (r.en !== 8) begin bad++; $display("FAIL sqrt_enable_cycles: got %0d want 8", r.en); end
    total++; if (r.t_rdy !== 14) begin bad++; $display("FAIL sqrt_ready_time: got %0d want 14", r.t_rdy); end
    total++; if (r.cnt_bad) begin bad++; $display("FAIL sqrt_count_seq: got bad=1 want 0"); end
  endtask

  task automatic test_errors();
    res_t r;
    do_op(2'd1, 1, 3, NEVER, 1'b1, 2, NEVER, r);
    total++; if (r.en !== 0 || r.rdy !== 0) begin bad++; $display("FAIL div0_no_calc: got en=%0d rdy=%0d want 0/0", r.en, r.rdy); end
    total++; if (r.t_err !== 6 || r.err !== 2) begin bad++; $display("FAIL div0_error: got t=%0d n=%0d want 6/2", r.t_err, r.err); end
    total++; if (r.t_idle !== 8) begin bad++; $display("FAIL div0_idle: got %0d want 8", r.t_idle); end
    do_op(2'd3, 1, 3, NEVER, 1'b0, 1, NEVER, r);
    total++; if (r.t_err !== 6 || r.en !== 0 || r.veri !== 1) begin bad++; $display("FAIL illegal_op: got t=%0d en=%0d veri=%0d want 6/0/1", r.t_err, r.en, r.veri); end
    total++; if (r.t_idle !== 7) begin bad++; $display("FAIL illegal_op_idle: got %0d want 7", r.t_idle); end
  endtask

  task automatic test_start_ignored();
    res_t r;
    do_op(2'd0, 1, 3, NEVER, 1'b0, 1, 10, r);
    total++; if (r.opq_bad) begin bad++; $display("FAIL start_in_calc_opq: got changed want stable"); end
    total++; if (r.en !== 16 || r.t_rdy !== 22) begin bad++; $display("FAIL start_in_calc_flow: got en=%0d rdy_t=%0d want 16/22", r.en, r.t_rdy); end
  endtask

  task automatic test_timeout();
    res_t r;
    do_op(2'd0, NEVER, NEVER, NEVER, 1'b0, 1, NEVER, r);
    total++; if (r.t_err !== 11 || r.lx !== 0) begin bad++; $display("FAIL tmo_x: got t=%0d lx=%0d want 11/0", r.t_err, r.lx); end
    do_op(2'd0, 1, NEVER, NEVER, 1'b0, 1, NEVER, r);
    total++; if (r.t_err !== 13 || r.lx !== 1 || r.ly !== 0) begin bad++; $display("FAIL tmo_y: got t=%0d lx=%0d ly=%0d want 13/1/0", r.t_err, r.lx, r.ly); end
    do_op(2'd0, 10, 12, NEVER, 1'b0, 1, NEVER, r);
    total++; if (r.err !== 0 || r.lx !== 1) begin bad++; $display("FAIL tmo_race: got err=%0d lx=%0d want 0/1", r.err, r.lx); end
    total++; if (r.t_rdy !== 31 || r.en !== 16) begin bad++; $display("FAIL tmo_race_flow: got rdy_t=%0d en=%0d want 31/16", r.t_rdy, r.en); end
  endtask

  task automatic test_load_level();
    res_t r;
    do_op(2'd0, NEVER, NEVER, -1, 1'b0, 1, NEVER, r);
    total++; if (r.lx !== 0 || r.t_err !== 11) begin bad++; $display("FAIL held_before_start: got lx=%0d t=%0d want 0/11", r.lx, r.t_err); end
    do_op(2'd0, 1, NEVER, 1, 1'b0, 1, NEVER, r);
    total++; if (r.ly !== 0 || r.lx !== 1 || r.t_err !== 13) begin bad++; $display("FAIL held_across_xy: got lx=%0d ly=%0d t=%0d want 1/0/13", r.lx, r.ly, r.t_err); end
  endtask

  task automatic test_reset_mid();
    res_t r;
    bit   found;
    found = 1'b0;
    bus.start = 1'b1; bus.op = 2'd0;
    tick();
    bus.start = 1'b0;
    for (int t = 0; t < 50; t++) begin
      if (bus.enable && bus.count == CW'(5)) begin
        found = 1'b1;
        break;
      end
      bus.load = (t == 1) || (t == 3);
      tick();
    end
    bus.load = 1'b0;
    total++; if (!found) begin bad++; $display("FAIL rst_mid_reach: got count=5 unseen want seen"); end
    #2 rst = 1'b0;
    #1;
    total++; if (out_vec() !== '0) begin bad++; $display("FAIL rst_mid_async: got %h want 0", out_vec()); end
    tick(); tick();
    @(negedge clk) rst = 1'b1;
    tick();
    total++; if (out_vec() !== '0) begin bad++; $display("FAIL rst_mid_idle: got %h want 0", out_vec()); end
    do_op(2'd0, 1, 3, NEVER, 1'b0, 1, NEVER, r);
    total++; if (r.en !== 16 || r.t_rdy !== 22) begin bad++; $display("FAIL rst_mid_rerun: got en=%0d rdy_t=%0d want 16/22", r.en, r.t_rdy); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_back_to_back();
    test_sqrt();
    test_errors();
    test_start_ignored();
    test_timeout();
    test_load_level();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
